// File: rtl/uart_pkg.sv
// Shared TX FSM encodings, default register addresses and baud-divisor helper
// for the UART FIFO controller.
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_HOLD
  } tx_state_e;

  localparam logic [31:0] DEFAULT_DATA_ADDR = 32'hBFD003F8;
  localparam logic [31:0] DEFAULT_STAT_ADDR = 32'hBFD003FC;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_fifo_control_if.sv
// MEM-stage bus seen by the UART FIFO controller: CPU side is master, UART is slave.
interface uart_fifo_control_if;
  logic [3:0]  memOp_i;
  logic [31:0] addr_i;
  logic [31:0] storeData_i;
  logic [31:0] loadData_o;
  logic        pauseRequest;
  logic        dataReady;
  logic        writeReady;
  logic        rxOverrun_o;

  modport master (
    output memOp_i, addr_i, storeData_i,
    input  loadData_o, pauseRequest, dataReady, writeReady, rxOverrun_o
  );

  modport slave (
    input  memOp_i, addr_i, storeData_i,
    output loadData_o, pauseRequest, dataReady, writeReady, rxOverrun_o
  );
endinterface

// File: rtl/async_receiver.sv
// 8N1 serial receiver sampling mid-bit; a byte is held with RxD_data_ready
// until RxD_clear, and frames with a bad stop bit are dropped.
module async_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    input  logic       RxD_clear,
    output logic       RxD_data_ready,
    output logic [7:0] RxD_data
);
    localparam int unsigned CPB  = clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned HALF = CPB / 2;
    localparam int unsigned TW   = $clog2(CPB) + 1;

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    rx_state_e     state_q, state_d;
    logic [1:0]    sync_q;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bits_q, bits_d;
    logic [7:0]    shift_q, shift_d, data_q, data_d;
    logic          ready_q, ready_d, rxd_s;

    assign rxd_s          = sync_q[1];
    assign RxD_data_ready = ready_q;
    assign RxD_data       = data_q;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bits_d  = bits_q;
        shift_d = shift_q;
        data_d  = data_q;
        ready_d = ready_q;
        if (RxD_clear) ready_d = 1'b0;
        unique case (state_q)
            RxIdle: begin
                tick_d = '0;
                if (!rxd_s) state_d = RxStart;
            end
            RxStart: begin
                if (tick_q == TW'(HALF - 1)) begin
                    tick_d  = '0;
                    bits_d  = '0;
                    state_d = rxd_s ? RxIdle : RxData;
                end else tick_d = tick_q + 1'b1;
            end
            RxData: begin
                if (tick_q == TW'(CPB - 1)) begin
                    tick_d  = '0;
                    shift_d = {rxd_s, shift_q[7:1]};
                    bits_d  = bits_q + 1'b1;
                    if (bits_q == 3'd7) state_d = RxStop;
                end else tick_d = tick_q + 1'b1;
            end
            RxStop: begin
                if (tick_q == TW'(CPB - 1)) begin
                    state_d = RxIdle;
                    if (rxd_s) begin
                        data_d  = shift_q;
                        ready_d = 1'b1;
                    end
                end else tick_d = tick_q + 1'b1;
            end
            default: state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RxIdle;
            sync_q  <= 2'b11;
            tick_q  <= '0;
            bits_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], RxD};
            tick_q  <= tick_d;
            bits_q  <= bits_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            ready_q <= ready_d;
        end
    end
endmodule

// File: rtl/async_transmitter.sv
// 8N1 serial transmitter. No reset: a frame in progress always runs to its stop
// bit, and any power-up value of the bit counter drains to idle on its own.
module async_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic       clk,
    input  logic       TxD_start,
    input  logic [7:0] TxD_data,
    output logic       TxD,
    output logic       TxD_busy
);
    localparam int unsigned CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned TW  = $clog2(CPB) + 1;

    logic [TW-1:0] tick_q;
    logic [3:0]    bits_q;
    logic [9:0]    shift_q;

    assign TxD_busy = bits_q != 4'd0;
    assign TxD      = TxD_busy ? shift_q[0] : 1'b1;

    always_ff @(posedge clk) begin
        if (!TxD_busy) begin
            tick_q <= '0;
            if (TxD_start) begin
                shift_q <= {1'b1, TxD_data, 1'b0};
                bits_q  <= 4'd10;
            end
        end else if (tick_q >= TW'(CPB - 1)) begin
            tick_q  <= '0;
            shift_q <= {1'b1, shift_q[9:1]};
            bits_q  <= bits_q - 1'b1;
        end else begin
            tick_q <= tick_q + 1'b1;
        end
    end
endmodule

// File: rtl/uart_fifo.sv
// Power-of-two circular FIFO with occupancy count; push is accepted at full
// when a pop happens in the same cycle.
module uart_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = count_q == CW'(DEPTH);
    assign empty   = count_q == '0;
    assign count   = count_q;
    assign rdata   = mem[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/uart_fifo_control.sv
// Memory-mapped UART with RX/TX FIFOs and MEM-stage stall; define
// UART_STATUS_REG_EN to map the status register at STAT_ADDR.
`ifndef MEM_LB
`define MEM_LB 4'd1
`endif
`ifndef MEM_SB
`define MEM_SB 4'd5
`endif

module uart_fifo_control
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 9600,
    parameter logic [31:0] DATA_ADDR  = DEFAULT_DATA_ADDR,
    parameter logic [31:0] STAT_ADDR  = DEFAULT_STAT_ADDR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rxd,
    output logic               txd,
    uart_fifo_control_if.slave bus
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_e     tx_state_q, tx_state_d;
    logic [7:0]    tx_head, rx_head, rx_byte;
    logic [CW-1:0] tx_count, rx_count;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          tx_push, tx_pop, rx_push, rx_pop;
    logic          tx_start, tx_busy, rx_ready, rx_clear;
    logic          sb_data, lb_data, lb_stat, stat_read, overrun_set;
    logic          rx_overrun_q, rx_overrun_d;
    logic [31:0]   status_word;
    logic          unused_store;

    assign unused_store = ^bus.storeData_i[31:8];

    // Every bus decode is gated by rst so no stall or load data leaks out during reset.
    assign sb_data = rst && bus.memOp_i == `MEM_SB && bus.addr_i == DATA_ADDR;
    assign lb_data = rst && bus.memOp_i == `MEM_LB && bus.addr_i == DATA_ADDR;
    assign lb_stat = rst && bus.memOp_i == `MEM_LB && bus.addr_i == STAT_ADDR;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_start   = 1'b0;
        tx_pop     = 1'b0;
        unique case (tx_state_q)
            TX_IDLE:  if (!tx_empty && !tx_busy) tx_state_d = TX_START;
            TX_START: begin
                tx_start   = rst;
                tx_pop     = rst;
                tx_state_d = TX_HOLD;
            end
            TX_HOLD:  if (tx_busy) tx_state_d = TX_IDLE;
            default:  tx_state_d = TX_IDLE;
        endcase
    end

    assign tx_push     = sb_data && (!tx_full || tx_pop);
    assign rx_pop      = lb_data && !rx_empty;
    assign rx_clear    = rst && rx_ready;
    assign rx_push     = rx_clear && (!rx_full || rx_pop);
    assign overrun_set = rx_clear && rx_full && !rx_pop;

`ifdef UART_STATUS_REG_EN
    assign status_word = {29'b0, rx_overrun_q, bus.dataReady, bus.writeReady};
    assign stat_read   = lb_stat;
`else
    assign status_word = '0;
    assign stat_read   = 1'b0;
`endif

    always_comb begin
        rx_overrun_d = rx_overrun_q;
        if (stat_read)   rx_overrun_d = 1'b0;
        if (overrun_set) rx_overrun_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state_q   <= TX_IDLE;
            rx_overrun_q <= 1'b0;
        end else begin
            tx_state_q   <= tx_state_d;
            rx_overrun_q <= rx_overrun_d;
        end
    end

    assign bus.pauseRequest = (sb_data && tx_full && !tx_pop) || (lb_data && rx_empty);
    assign bus.loadData_o   = rx_pop  ? {24'b0, rx_head} :
                              lb_stat ? status_word : 32'b0;
    assign bus.dataReady    = rx_count != '0;
    assign bus.writeReady   = tx_count != CW'(FIFO_DEPTH);
    assign bus.rxOverrun_o  = rx_overrun_q;

    uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (bus.storeData_i[7:0]),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdata (rx_byte),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    async_transmitter #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_tx (
        .clk       (clk),
        .TxD_start (tx_start),
        .TxD_data  (tx_head),
        .TxD       (txd),
        .TxD_busy  (tx_busy)
    );

    async_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
        .clk            (clk),
        .rst            (rst),
        .RxD            (rxd),
        .RxD_clear      (rx_clear),
        .RxD_data_ready (rx_ready),
        .RxD_data       (rx_byte)
    );
endmodule

// File: tb/tb_uart_fifo_control.sv
// Scoreboard bench for uart_fifo_control at 8 clocks per bit; status-register
// expectations follow UART_STATUS_REG_EN.
`ifndef MEM_LB
`define MEM_LB 4'd1
`endif
`ifndef MEM_SB
`define MEM_SB 4'd5
`endif

module tb_uart_fifo_control;
    localparam logic [31:0] DATA_A = 32'hBFD003F8;
    localparam logic [31:0] STAT_A = 32'hBFD003FC;
    localparam logic [3:0]  OP_NOP = 4'd0;
    localparam logic [3:0]  OP_LB  = `MEM_LB;
    localparam logic [3:0]  OP_SB  = `MEM_SB;
    localparam int          CPB    = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rxd = 1'b1;
    logic txd;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    logic [7:0] mon_byte, mon_exp;

    uart_fifo_control_if bus ();

    uart_fifo_control #(.FIFO_DEPTH(16), .CLK_FREQ(800), .BAUD(100)) dut (
        .clk (clk),
        .rst (rst),
        .rxd (rxd),
        .txd (txd),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Decode every frame on txd and compare against the TX scoreboard.
    initial begin : tx_monitor
        forever begin
            @(negedge txd);
            repeat (CPB / 2) @(negedge clk);
            checks++;
            if (txd !== 1'b0) begin
                errors++;
                $display("FAIL tx_start_bit: got %b expected 0", txd);
            end
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                mon_byte[i] = txd;
            end
            repeat (CPB) @(negedge clk);
            checks++;
            if (txd !== 1'b1) begin
                errors++;
                $display("FAIL tx_stop_bit: got %b expected 1", txd);
            end
            checks++;
            if (tx_exp.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected_byte: got %02h expected none", mon_byte);
            end else begin
                mon_exp = tx_exp.pop_front();
                if (mon_byte !== mon_exp) begin
                    errors++;
                    $display("FAIL tx_byte: got %02h expected %02h", mon_byte, mon_exp);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (CPB + 2) @(negedge clk);
    endtask

    task automatic bus_op(input logic [3:0] op, input logic [31:0] a, input logic [7:0] wd,
                          output int stalls, output logic [31:0] rd,
                          output logic [31:0] stall_rd);
        stalls   = 0;
        stall_rd = '0;
        @(negedge clk);
        bus.memOp_i     = op;
        bus.addr_i      = a;
        bus.storeData_i = {24'hA5A5A5, wd};
        #1;
        while (bus.pauseRequest === 1'b1 && stalls < 3000) begin
            if (stalls == 0) stall_rd = bus.loadData_o;
            stalls++;
            @(negedge clk);
            #1;
        end
        if (stalls >= 3000) begin
            checks++;
            errors++;
            $display("FAIL bus_timeout: got stall %0d cycles expected release", stalls);
        end
        rd = bus.loadData_o;
        @(posedge clk);
        #1;
        bus.memOp_i = OP_NOP;
    endtask

    task automatic wait_tx_drain();
        int n = 0;
        while (tx_exp.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tx_exp.size() != 0) begin
            errors++;
            $display("FAIL tx_drain: got %0d bytes pending expected 0", tx_exp.size());
        end
    endtask

    task automatic drain_rx(input int n);
        int st;
        logic [31:0] rd, srd;
        logic [7:0] e;
        for (int i = 0; i < n; i++) begin
            e = rx_exp.pop_front();
            bus_op(OP_LB, DATA_A, 8'h00, st, rd, srd);
            checks++;
            if (st != 0 || rd !== {24'h0, e}) begin
                errors++;
                $display("FAIL rx_drain[%0d]: got %08h stall %0d expected %08h stall 0",
                         i, rd, st, {24'h0, e});
            end
        end
        checks++;
        if (bus.dataReady !== 1'b0) begin
            errors++;
            $display("FAIL rx_drain_empty: got dataReady %b expected 0", bus.dataReady);
        end
    endtask

    task automatic test_reset();
        int st, n;
        logic [31:0] rd, srd;
        bus.memOp_i = OP_NOP;
        bus.addr_i = '0;
        bus.storeData_i = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (bus.dataReady !== 1'b0 || bus.writeReady !== 1'b1 || bus.pauseRequest !== 1'b0 ||
            bus.loadData_o !== 32'h0 || bus.rxOverrun_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: got dr %b wr %b pr %b ld %08h ov %b expected 0 1 0 0 0",
                     bus.dataReady, bus.writeReady, bus.pauseRequest, bus.loadData_o,
                     bus.rxOverrun_o);
        end
        rst = 1'b1;
        // Mid-transmit reset: 0x10 is on the wire, 0x11 still queued.
        tx_exp.push_back(8'h10);
        bus_op(OP_SB, DATA_A, 8'h10, st, rd, srd);
        tx_exp.push_back(8'h11);
        bus_op(OP_SB, DATA_A, 8'h11, st, rd, srd);
        n = 0;
        while (txd !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (txd !== 1'b0) begin
            errors++;
            $display("FAIL reset_tx_started: got txd %b expected 0", txd);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bus.memOp_i = OP_LB;
        bus.addr_i = DATA_A;
        #1;
        checks++;
        if (bus.pauseRequest !== 1'b0 || bus.loadData_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_stall_gated: got pr %b ld %08h expected 0 0",
                     bus.pauseRequest, bus.loadData_o);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bus.memOp_i = OP_NOP;
        #1;
        checks++;
        if (bus.dataReady !== 1'b0 || bus.writeReady !== 1'b1 || bus.pauseRequest !== 1'b0 ||
            bus.loadData_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_tx: got dr %b wr %b pr %b ld %08h expected 0 1 0 0",
                     bus.dataReady, bus.writeReady, bus.pauseRequest, bus.loadData_o);
        end
        while (tx_exp.size() > 1) void'(tx_exp.pop_back());
    endtask

    // Runs while the 0x10 frame is still on the wire, so nothing pops early.
    task automatic test_tx_burst();
        int st;
        logic [31:0] rd, srd;
        for (int i = 0; i < 17; i++) begin
            tx_exp.push_back(8'h41 + 8'(i));
            bus_op(OP_SB, DATA_A, 8'h41 + 8'(i), st, rd, srd);
            checks++;
            if ((i < 16 && st != 0) || (i == 16 && st == 0)) begin
                errors++;
                $display("FAIL tx_burst_stall[%0d]: got %0d cycles expected %s", i, st,
                         (i < 16) ? "0" : ">0");
            end
            if (i == 15) begin
                checks++;
                if (bus.writeReady !== 1'b0) begin
                    errors++;
                    $display("FAIL tx_full_flag: got writeReady %b expected 0", bus.writeReady);
                end
            end
        end
        wait_tx_drain();
    endtask

    task automatic test_rx_read();
        int st;
        logic [31:0] rd, srd, e;
        rx_exp.push_back(8'h5A);
        send_byte(8'h5A);
        checks++;
        if (bus.dataReady !== 1'b1) begin
            errors++;
            $display("FAIL rx_data_ready: got %b expected 1", bus.dataReady);
        end
        e = {24'h0, rx_exp.pop_front()};
        bus_op(OP_LB, DATA_A, 8'h00, st, rd, srd);
        checks++;
        if (st != 0 || rd !== e) begin
            errors++;
            $display("FAIL rx_read: got %08h stall %0d expected %08h stall 0", rd, st, e);
        end
        checks++;
        if (bus.dataReady !== 1'b0) begin
            errors++;
            $display("FAIL rx_ready_fall: got %b expected 0", bus.dataReady);
        end
    endtask

    task automatic test_rx_stall();
        int st;
        logic [31:0] rd, srd, e;
        fork
            bus_op(OP_LB, DATA_A, 8'h00, st, rd, srd);
            begin
                repeat (1000) @(negedge clk);
                rx_exp.push_back(8'hC3);
                send_byte(8'hC3);
            end
        join
        e = {24'h0, rx_exp.pop_front()};
        checks++;
        if (st < 1000 || srd !== 32'h0 || rd !== e) begin
            errors++;
            $display("FAIL rx_empty_stall: got stall %0d stall_data %08h data %08h expected >=1000 0 %08h",
                     st, srd, rd, e);
        end
    endtask

    task automatic test_simultaneous();
        logic pr;
        logic [31:0] rd, e;
        for (int i = 0; i < 16; i++) begin
            rx_exp.push_back(8'h60 + 8'(i));
            send_byte(8'h60 + 8'(i));
        end
        e = {24'h0, rx_exp[0]};
        rx_exp.push_back(8'h70);
        fork
            send_byte(8'h70);
            begin
                int n = 0;
                @(negedge clk);
                // Align the read with the cycle the receiver presents its byte.
                while (dut.rx_ready !== 1'b1 && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                bus.memOp_i = OP_LB;
                bus.addr_i = DATA_A;
                #1;
                pr = bus.pauseRequest;
                rd = bus.loadData_o;
                @(posedge clk);
                #1;
                bus.memOp_i = OP_NOP;
            end
        join
        void'(rx_exp.pop_front());
        checks++;
        if (pr !== 1'b0 || rd !== e) begin
            errors++;
            $display("FAIL simul_pop: got pr %b data %08h expected 0 %08h", pr, rd, e);
        end
        checks++;
        if (bus.rxOverrun_o !== 1'b0 || bus.dataReady !== 1'b1) begin
            errors++;
            $display("FAIL simul_no_overrun: got ov %b dr %b expected 0 1",
                     bus.rxOverrun_o, bus.dataReady);
        end
        drain_rx(16);
    endtask

    task automatic test_overrun();
        int st;
        logic [31:0] rd, srd, exp_stat;
        logic exp_ov;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) rx_exp.push_back(8'h80 + 8'(i));
            send_byte(8'h80 + 8'(i));
        end
        checks++;
        if (bus.rxOverrun_o !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got %b expected 1", bus.rxOverrun_o);
        end
        // First byte leaves for the transmitter at once; the next 16 fill the TX FIFO.
        for (int i = 0; i < 17; i++) begin
            tx_exp.push_back(8'hA0 + 8'(i));
            bus_op(OP_SB, DATA_A, 8'hA0 + 8'(i), st, rd, srd);
        end
        checks++;
        if (bus.writeReady !== 1'b0) begin
            errors++;
            $display("FAIL overrun_tx_full: got writeReady %b expected 0", bus.writeReady);
        end
`ifdef UART_STATUS_REG_EN
        exp_stat = 32'h6;
        exp_ov   = 1'b0;
`else
        exp_stat = 32'h0;
        exp_ov   = 1'b1;
`endif
        bus_op(OP_LB, STAT_A, 8'h00, st, rd, srd);
        checks++;
        if (st != 0 || rd !== exp_stat) begin
            errors++;
            $display("FAIL status_read: got %08h stall %0d expected %08h stall 0", rd, st, exp_stat);
        end
        checks++;
        if (bus.rxOverrun_o !== exp_ov) begin
            errors++;
            $display("FAIL overrun_after_status: got %b expected %b", bus.rxOverrun_o, exp_ov);
        end
        drain_rx(16);
        wait_tx_drain();
    endtask

    initial begin
        test_reset();
        test_tx_burst();
        test_rx_read();
        test_rx_stall();
        test_simultaneous();
        test_overrun();
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
